// File: rtl/cpu_pkg.sv
// Shared ISA and sequencer definitions for the 8-bit RISC CPU controller.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  // Eight phases take binary 0-7; HALT sits outside that range.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALT       = 4'd8
  } state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_ir.sv
// Instruction register: captures the fetched word and splits opcode/address fields.
module instruction_register
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] operand_addr
);

  logic [DATA_W-1:0] ir;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (load) begin
      ir <= data_in;
    end
  end

  assign opcode       = ir[DATA_W-1:ADDR_W];
  assign operand_addr = ir[ADDR_W-1:0];

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: phase FSM, strobe decode, skip and halt flags.
//
// state        | meaning
// INST_ADDR    | PC address on bus; wait here while run is low
// INST_FETCH   | read instruction word
// INST_LOAD    | read continues, IR captures on closing edge
// IDLE         | decode slot, no strobes
// OP_ADDR      | operand address on bus; HLT diverts to HALT
// OP_FETCH     | operand read for ALU-class ops
// ALU_OP       | operand read / STO drives bus; skip decision sampled
// STORE        | accumulator load or memory write; PC enable pulse
// HALT         | parked until reset
module cpu_controller
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              acc_zero,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] operand_addr,
  output logic              skz_cmp,
  output logic              en_cpu,
  output logic              addr_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              ir_load,
  output logic              acc_load,
  output logic              data_oe,
  output logic              halted
);

  state_t state;
  logic   alu_class;
  logic   is_sto;

  instruction_register u_ir (
    .clock        (clock),
    .reset        (reset),
    .load         (ir_load),
    .data_in      (mem_data_in),
    .opcode       (opcode),
    .operand_addr (operand_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_INST_ADDR;
      skz_cmp <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        S_INST_ADDR:  if (run) state <= S_INST_FETCH;
        S_INST_FETCH: state <= S_INST_LOAD;
        S_INST_LOAD:  state <= S_IDLE;
        S_IDLE:       state <= S_OP_ADDR;
        S_OP_ADDR: begin
          if (opcode == OP_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_OP_FETCH;
          end
        end
        S_OP_FETCH:   state <= S_ALU_OP;
        S_ALU_OP: begin
          skz_cmp <= (opcode == OP_SKZ) && acc_zero;
          state   <= S_STORE;
        end
        S_STORE:      state <= S_INST_ADDR;
        S_HALT:       state <= S_HALT;
        default:      state <= S_INST_ADDR;
      endcase
    end
  end

  // Decode uses only state and the registered opcode, never mem_data_in.
  assign alu_class = is_alu_op(opcode);
  assign is_sto    = (opcode == OP_STO);

  always_comb begin
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    data_oe  = 1'b0;
    en_cpu   = 1'b0;
    case (state)
      S_INST_FETCH: mem_rd = 1'b1;
      S_INST_LOAD: begin
        mem_rd  = 1'b1;
        ir_load = 1'b1;
      end
      S_OP_ADDR:  addr_sel = 1'b1;
      S_OP_FETCH: begin
        addr_sel = 1'b1;
        mem_rd   = alu_class;
      end
      S_ALU_OP: begin
        addr_sel = 1'b1;
        mem_rd   = alu_class;
        data_oe  = is_sto;
      end
      S_STORE: begin
        addr_sel = 1'b1;
        en_cpu   = 1'b1;
        acc_load = alu_class;
        mem_wr   = is_sto;
        data_oe  = is_sto;
      end
      default: ;
    endcase
  end

endmodule
